// File: rtl/fpadd_link_pkg.sv
// Shared definitions for the adder's one-bit setup/readback link.
// Used by both the transmitter (setup_serializer) and the serial-in receive register.
package fpadd_link_pkg;

    // Transmitter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    // Default word width carried by the link.
    localparam int unsigned LINK_WIDTH = 8;

    // Default number of idle cycles forced between words.
    localparam int unsigned LINK_GAP_DEFAULT = 1;

endpackage

// File: rtl/setup_serializer.sv
// Parallel-in, serial-out transmitter for the adder's setup/readback link.
// A word is accepted through a load/ready handshake and shifted out LSB-first,
// one bit per clock, with en_out qualifying each valid bit. A programmable number
// of idle cycles separates consecutive words. All outputs are registered.
module setup_serializer
    import fpadd_link_pkg::*;
#(
    parameter int unsigned WIDTH      = LINK_WIDTH,       // 2..32
    parameter int unsigned GAP_CYCLES = LINK_GAP_DEFAULT  // 0..15
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_in,
    input  logic             abort_in,
    output logic             ready_out,
    output logic             serial_out,
    output logic             en_out,
    output logic             done_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    // Count value in the cycle that carries the final bit.
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

    // Count value in the final gap cycle; unused when GAP_CYCLES is zero.
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    ser_state_t       state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       gap_cnt;

    // Control FSM, datapath and registered outputs in one clocked process.
    // shreg[0] always holds the bit currently on serial_out, so serial_out is
    // loaded with the bit that will sit in shreg[0] after this edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ready_out  <= 1'b1;
            serial_out <= 1'b0;
            en_out     <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            // done_out is a single-cycle pulse unless re-asserted below.
            done_out <= 1'b0;

            if (abort_in) begin
                // Abort outranks loads; in IDLE it simply blocks a same-cycle load.
                if (state != IDLE) begin
                    state      <= IDLE;
                    shreg      <= '0;
                    bit_cnt    <= '0;
                    gap_cnt    <= '0;
                    ready_out  <= 1'b1;
                    serial_out <= 1'b0;
                    en_out     <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (load_in) begin
                            state      <= SHIFT;
                            shreg      <= parallel_in;
                            bit_cnt    <= '0;
                            ready_out  <= 1'b0;
                            en_out     <= 1'b1;
                            serial_out <= parallel_in[0];
                        end
                    end

                    SHIFT: begin
                        if (bit_cnt == BIT_LAST) begin
                            // Last bit is on the wire this cycle; close the frame.
                            shreg      <= '0;
                            bit_cnt    <= '0;
                            en_out     <= 1'b0;
                            serial_out <= 1'b0;
                            done_out   <= 1'b1;
                            if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end else begin
                                state     <= IDLE;
                                ready_out <= 1'b1;
                            end
                        end else begin
                            shreg      <= shreg >> 1;
                            serial_out <= shreg[1];
                            bit_cnt    <= bit_cnt + 1'b1;
                        end
                    end

                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state     <= IDLE;
                            gap_cnt   <= '0;
                            ready_out <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state      <= IDLE;
                        ready_out  <= 1'b1;
                        en_out     <= 1'b0;
                        serial_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_setup_serializer.sv
// Directed bench for setup_serializer: one instance with GAP_CYCLES=1 and one with
// GAP_CYCLES=0, plus a behavioural serial-in receive register for loopback.
module tb_setup_serializer;
    import fpadd_link_pkg::*;

    logic       clk;
    logic       rst_n;

    // Instance with a one-cycle gap.
    logic [7:0] pin1;
    logic       load1, abort1;
    logic       ready1, ser1, en1, done1;

    // Instance with no gap.
    logic [7:0] pin0;
    logic       load0, abort0;
    logic       ready0, ser0, en0, done0;

    int checks   = 0;
    int failures = 0;
    int done1_cnt = 0;
    int done0_cnt = 0;
    logic [7:0] rx;

    setup_serializer #(.WIDTH(8), .GAP_CYCLES(1)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .parallel_in (pin1),
        .load_in     (load1),
        .abort_in    (abort1),
        .ready_out   (ready1),
        .serial_out  (ser1),
        .en_out      (en1),
        .done_out    (done1)
    );

    setup_serializer #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .parallel_in (pin0),
        .load_in     (load0),
        .abort_in    (abort0),
        .ready_out   (ready0),
        .serial_out  (ser0),
        .en_out      (en0),
        .done_out    (done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive register model: LSB-first shift-in qualified by en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx <= 8'h00;
        else if (en1) rx <= {ser1, rx[7:1]};
    end

    always @(posedge clk) begin
        if (done1) done1_cnt <= done1_cnt + 1;
        if (done0) done0_cnt <= done0_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_en(input bit use0);
        return use0 ? en0 : en1;
    endfunction
    function automatic logic get_ser(input bit use0);
        return use0 ? ser0 : ser1;
    endfunction
    function automatic logic get_done(input bit use0);
        return use0 ? done0 : done1;
    endfunction
    function automatic logic get_ready(input bit use0);
        return use0 ? ready0 : ready1;
    endfunction

    task automatic drive(input bit use0, input logic [7:0] d, input logic ld);
        if (use0) begin
            pin0  = d;
            load0 = ld;
        end else begin
            pin1  = d;
            load1 = ld;
        end
    endtask

    // Load d from a ready state, check all 8 bits; returns in the done cycle.
    task automatic send(input bit use0, input logic [7:0] d);
        check("ready_before_load", get_ready(use0), 1'b1);
        drive(use0, d, 1'b1);
        @(negedge clk);
        drive(use0, d, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("en_during_bit", get_en(use0), 1'b1);
            check("serial_bit", get_ser(use0), d[k]);
            check("no_done_during_bit", get_done(use0), 1'b0);
            @(negedge clk);
        end
        check("done_pulse", get_done(use0), 1'b1);
        check("en_after_frame", get_en(use0), 1'b0);
    endtask

    initial begin
        int d1;
        rst_n  = 1'b0;
        pin1   = 8'h00; load1 = 1'b0; abort1 = 1'b0;
        pin0   = 8'h00; load0 = 1'b0; abort0 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_ready", ready1, 1'b1);
        check("rst_en", en1, 1'b0);
        check("rst_serial", ser1, 1'b0);
        check("rst_done", done1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8'hA5 with GAP=1: bits 1,0,1,0,0,1,0,1; done in cycle 9, ready in cycle 10.
        send(1'b0, 8'hA5);
        check("gap_ready_low", ready1, 1'b0);
        check("loop_a5", rx, 8'hA5);
        @(negedge clk);
        check("gap_ready_back", ready1, 1'b1);
        check("gap_done_single", done1, 1'b0);
        check("gap_en_low", en1, 1'b0);

        // Loopback words.
        send(1'b0, 8'h00);
        check("loop_00", rx, 8'h00);
        @(negedge clk);
        send(1'b0, 8'hFF);
        check("loop_ff", rx, 8'hFF);
        @(negedge clk);
        send(1'b0, 8'h3C);
        check("loop_3c", rx, 8'h3C);
        @(negedge clk);

        // Back-to-back with GAP=0: next load in the done cycle, one en-low cycle.
        send(1'b1, 8'h81);
        check("b2b_ready_in_done", ready0, 1'b1);
        send(1'b1, 8'h7E);
        check("b2b_ready_end", ready0, 1'b1);
        @(negedge clk);
        check("b2b_done_count", done0_cnt, 2);
        check("b2b_idle_en", en0, 1'b0);

        // load held high while busy; parallel_in changes mid-word.
        pin1  = 8'h12;
        load1 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) pin1 = 8'hFF;
            check("held_en", en1, 1'b1);
            check("held_bit", ser1, 1'(8'h12 >> k));
            @(negedge clk);
        end
        check("held_done", done1, 1'b1);
        check("held_ready_low", ready1, 1'b0);
        check("held_rx", rx, 8'h12);
        load1 = 1'b0;
        @(negedge clk);
        check("held_ready", ready1, 1'b1);
        @(negedge clk);
        check("held_no_extra", en1, 1'b0);

        // abort and load together in IDLE: load ignored.
        abort1 = 1'b1;
        load1  = 1'b1;
        pin1   = 8'hFF;
        @(negedge clk);
        abort1 = 1'b0;
        load1  = 1'b0;
        check("idle_abort_en", en1, 1'b0);
        check("idle_abort_ready", ready1, 1'b1);
        @(negedge clk);
        check("idle_abort_en2", en1, 1'b0);

        // Abort during bit 3 of 8'hC3.
        d1 = done1_cnt;
        pin1  = 8'hC3;
        load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("abort_pre_bit", ser1, 1'(8'hC3 >> k));
            check("abort_pre_en", en1, 1'b1);
            if (k < 3) @(negedge clk);
        end
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("abort_en_low", en1, 1'b0);
        check("abort_serial_low", ser1, 1'b0);
        check("abort_ready", ready1, 1'b1);
        check("abort_no_done", done1, 1'b0);
        @(negedge clk);
        check("abort_no_done2", done1, 1'b0);
        check("abort_done_count", done1_cnt, d1);
        send(1'b0, 8'h01);
        @(negedge clk);
        check("abort_recover_ready", ready1, 1'b1);

        // Half-cycle reset during bit 5 of 8'h5A.
        pin1  = 8'h5A;
        load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("rst_pre_bit", ser1, 1'(8'h5A >> k));
            if (k < 5) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("async_rst_en", en1, 1'b0);
        check("async_rst_ready", ready1, 1'b1);
        check("async_rst_serial", ser1, 1'b0);
        check("async_rst_done", done1, 1'b0);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", ready1, 1'b1);
        check("post_rst_en", en1, 1'b0);
        check("post_rst_done", done1, 1'b0);
        send(1'b0, 8'h5A);
        check("post_rst_rx", rx, 8'h5A);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
